// File: rtl/ubfly_collect_pkg.sv
// Shared types and helpers for the unary butterfly capture stage.
package ubfly_collect_pkg;

    // Capture sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FILL = 3'd2,
        ST_ACC  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Stream period L = 2^bw cycles.
    function automatic int unsigned streamLen(input int unsigned bw);
        return 32'd1 << bw;
    endfunction

    // A count of 0..L needs one bit more than the weight width.
    function automatic int unsigned cntWidth(input int unsigned bw);
        return bw + 32'd1;
    endfunction

endpackage

// File: rtl/ubfly_stream_cnt.sv
// Single-channel ones counter: synchronous clear, enable, async active-low reset.
module ubfly_stream_cnt #(
    parameter int unsigned W = 9
) (
    input  logic         iClk,
    input  logic         iRstN,
    input  logic         iClr,
    input  logic         iEn,
    input  logic         iBit,
    output logic [W-1:0] oCnt
);

    localparam logic [W-1:0] ONE = W'(1);

    // Clear wins over counting; count only enabled ones.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN)
            oCnt <= '0;
        else if (iClr)
            oCnt <= '0;
        else if (iEn && iBit)
            oCnt <= oCnt + ONE;
    end

endmodule

// File: rtl/ubfly_collect.sv
// Capture stage for the unary butterfly: pulses the weight load, drops the
// pipeline-fill cycles, counts ones on four streams for one full period and
// hands the counts downstream with a valid/ready handshake.
module ubfly_collect
    import ubfly_collect_pkg::*;
#(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned SKIP     = 2
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iStart,
    input  logic              iReal0,
    input  logic              iImg0,
    input  logic              iReal1,
    input  logic              iImg1,
    output logic              oLoadW,
    output logic              oBusy,
    output logic              oValid,
    input  logic              iReady,
    output logic [BITWIDTH:0] oCntReal0,
    output logic [BITWIDTH:0] oCntImg0,
    output logic [BITWIDTH:0] oCntReal1,
    output logic [BITWIDTH:0] oCntImg1
);

    localparam int unsigned          CW        = cntWidth(BITWIDTH);
    localparam logic [BITWIDTH-1:0]  ACC_LAST  = BITWIDTH'(streamLen(BITWIDTH) - 1);
    localparam logic [BITWIDTH-1:0]  CYC_ONE   = BITWIDTH'(1);
    localparam logic [3:0]           SKIP_LAST = (SKIP > 0) ? 4'(SKIP - 1) : 4'd0;

    state_e              state, stateNext;
    logic [BITWIDTH-1:0] cycCnt;
    logic [3:0]          skipCnt;
    logic                loadW;

    // State register.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN)
            state <= ST_IDLE;
        else
            state <= stateNext;
    end

    // Next-state logic; iStart only matters in IDLE.
    always_comb begin
        stateNext = state;
        unique case (state)
            ST_IDLE: if (iStart) stateNext = ST_LOAD;
            ST_LOAD: stateNext = (SKIP > 0) ? ST_FILL : ST_ACC;
            ST_FILL: if (skipCnt == SKIP_LAST) stateNext = ST_ACC;
            ST_ACC:  if (cycCnt == ACC_LAST) stateNext = ST_DONE;
            ST_DONE: if (iReady) stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // Fill and stream-period counters, restarted by the load cycle.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cycCnt  <= '0;
            skipCnt <= '0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    cycCnt  <= '0;
                    skipCnt <= '0;
                end
                ST_FILL: skipCnt <= skipCnt + 4'd1;
                ST_ACC:  cycCnt  <= cycCnt + CYC_ONE;
                default: ;
            endcase
        end
    end

    // Registered load pulse, high for exactly the LOAD cycle.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN)
            loadW <= 1'b0;
        else
            loadW <= (stateNext == ST_LOAD);
    end

    logic                 accClr, accEn;
    logic [3:0]           streamBits;
    logic [3:0][CW-1:0]   cnt;

    assign accClr     = (state == ST_LOAD);
    assign accEn      = (state == ST_ACC);
    assign streamBits = {iImg1, iReal1, iImg0, iReal0};

    for (genvar g = 0; g < 4; g++) begin : gCh
        ubfly_stream_cnt #(.W(CW)) uCnt (
            .iClk  (iClk),
            .iRstN (iRstN),
            .iClr  (accClr),
            .iEn   (accEn),
            .iBit  (streamBits[g]),
            .oCnt  (cnt[g])
        );
    end

    // Counters only move in LOAD/ACC, so they are stable through DONE and
    // keep their value after acceptance until the next LOAD.
    assign oCntReal0 = cnt[0];
    assign oCntImg0  = cnt[1];
    assign oCntReal1 = cnt[2];
    assign oCntImg1  = cnt[3];
    assign oLoadW    = loadW;
    assign oBusy     = (state != ST_IDLE);
    assign oValid    = (state == ST_DONE);

endmodule

// File: tb/tb_ubfly_collect.sv
// Scoreboard bench for ubfly_collect: each evaluation's stimulus is generated
// up front, expected counts are the plain sums of the bits presented during
// the L cycles that follow the load and fill cycles.
module tb_ubfly_collect;

    localparam int BW   = 8;
    localparam int SKIP = 2;
    localparam int L    = 1 << BW;
    localparam int LAT  = 2 + SKIP + L;      // iStart cycle to first DONE cycle
    localparam int NST  = SKIP + L + 2;      // cycles 0..SKIP+L+1
    localparam int WIN0 = SKIP + 2;          // first accumulated cycle

    logic        iClk = 1'b0;
    logic        iRstN, iStart, iReady;
    logic        iReal0, iImg0, iReal1, iImg1;
    logic        oLoadW, oBusy, oValid;
    logic [BW:0] oCntReal0, oCntImg0, oCntReal1, oCntImg1;

    ubfly_collect #(.BITWIDTH(BW), .SKIP(SKIP)) dut (
        .iClk(iClk), .iRstN(iRstN), .iStart(iStart),
        .iReal0(iReal0), .iImg0(iImg0), .iReal1(iReal1), .iImg1(iImg1),
        .oLoadW(oLoadW), .oBusy(oBusy), .oValid(oValid), .iReady(iReady),
        .oCntReal0(oCntReal0), .oCntImg0(oCntImg0),
        .oCntReal1(oCntReal1), .oCntImg1(oCntImg1)
    );

    always #5 iClk = ~iClk;

    typedef struct { int cnt[4]; int startCyc; } exp_t;
    exp_t expQ[$];

    int nTests = 0, nFail = 0;
    int cyc = 0, loadCnt = 0, loadCyc = 0, riseCyc = 0;
    bit prevV = 1'b0;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int outCnt(input int ch);
        case (ch)
            0: return int'(oCntReal0);
            1: return int'(oCntImg0);
            2: return int'(oCntReal1);
            default: return int'(oCntImg1);
        endcase
    endfunction

    // Monitor: samples mid-cycle, tracks load pulses and valid rise, and
    // scores every accepted result against the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge iClk);
            #2;
            if (!iRstN) begin
                prevV = 1'b0;
            end else begin
                if (oLoadW) begin
                    loadCnt++;
                    loadCyc = cyc;
                end
                if (oValid && !prevV) riseCyc = cyc;
                prevV = oValid;
                if (oValid && iReady) begin
                    if (expQ.size() == 0) begin
                        chk("unexpected result", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        for (int ch = 0; ch < 4; ch++)
                            chk($sformatf("count ch%0d", ch), outCnt(ch), e.cnt[ch]);
                        chk("latency", riseCyc - e.startCyc, LAT);
                    end
                end
            end
        end
    end

    // One evaluation. mode: 0 all ones, 1 zero/toggle/LFSR, 2 ones only in
    // load+fill, 3 random, 4 random with iStart spam. holdN: cycles of
    // iReady=0 in DONE. abortAt>=0: reset at that cycle, no result expected.
    task automatic runEval(input int mode, input int holdN, input int abortAt);
        logic [3:0] stim [NST];
        logic [7:0] lfsr;
        logic       fb;
        exp_t       ex;
        int         c, lc0;
        bit         done;

        lfsr = 8'($urandom_range(1, 255));
        for (int k = 0; k < NST; k++) begin
            fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
            lfsr = {lfsr[6:0], fb};
            case (mode)
                0:       stim[k] = 4'b1111;
                1:       stim[k] = {lfsr[0], lfsr[0], 1'(k & 1), 1'b0};
                2:       stim[k] = (k < WIN0) ? 4'b1111 : 4'b0000;
                default: stim[k] = 4'($urandom);
            endcase
        end
        for (int ch = 0; ch < 4; ch++) begin
            ex.cnt[ch] = 0;
            for (int k = WIN0; k < WIN0 + L; k++) ex.cnt[ch] += int'(stim[k][ch]);
        end

        iReady = (holdN == 0);
        @(negedge iClk);
        ex.startCyc = cyc;
        if (abortAt < 0) expQ.push_back(ex);
        lc0    = loadCnt;
        iStart = 1'b1;
        {iImg1, iReal1, iImg0, iReal0} = stim[0];

        c = 1;
        done = 1'b0;
        while (!done) begin
            @(negedge iClk);
            if (abortAt >= 0 && c == abortAt) begin
                iRstN  = 1'b0;
                iStart = 1'b0;
                #2;
                chk("abort valid", int'(oValid), 0);
                chk("abort busy", int'(oBusy), 0);
                chk("abort loadW", int'(oLoadW), 0);
                for (int ch = 0; ch < 4; ch++)
                    chk($sformatf("abort count ch%0d", ch), outCnt(ch), 0);
                repeat (2) @(negedge iClk);
                iRstN = 1'b1;
                #2;
                chk("post-reset busy", int'(oBusy), 0);
                return;
            end
            if (oValid) begin
                done = 1'b1;
            end else if (c > LAT + 50) begin
                chk("valid timeout", 0, 1);
                iStart = 1'b0;
                return;
            end else begin
                iStart = (mode == 4 && c >= 2) ? 1'($urandom) : 1'b0;
                {iImg1, iReal1, iImg0, iReal0} = (c < NST) ? stim[c] : 4'($urandom);
                c++;
            end
        end

        chk("load cycle", loadCyc - ex.startCyc, 1);
        chk("load pulses", loadCnt - lc0, 1);

        for (int h = 0; h < holdN; h++) begin
            {iImg1, iReal1, iImg0, iReal0} = 4'($urandom);
            iStart = 1'($urandom);
            #2;
            chk("hold valid", int'(oValid), 1);
            for (int ch = 0; ch < 4; ch++)
                chk($sformatf("hold count ch%0d", ch), outCnt(ch), ex.cnt[ch]);
            @(negedge iClk);
        end

        // Handshake cycle with iStart high: must not launch a new run.
        iReady = 1'b1;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        #2;
        chk("valid drop", int'(oValid), 0);
        chk("idle busy", int'(oBusy), 0);
        chk("no extra load", loadCnt - lc0, 1);
        for (int ch = 0; ch < 4; ch++)
            chk($sformatf("held count ch%0d", ch), outCnt(ch), ex.cnt[ch]);
    endtask

    initial begin
        iRstN  = 1'b0;
        iStart = 1'b0;
        iReady = 1'b1;
        {iImg1, iReal1, iImg0, iReal0} = 4'b0000;
        repeat (3) @(negedge iClk);
        #2;
        chk("reset valid", int'(oValid), 0);
        chk("reset busy", int'(oBusy), 0);
        chk("reset loadW", int'(oLoadW), 0);
        for (int ch = 0; ch < 4; ch++)
            chk($sformatf("reset count ch%0d", ch), outCnt(ch), 0);
        iRstN = 1'b1;

        runEval(0, 0, -1);
        runEval(1, 0, -1);
        runEval(2, 0, -1);
        runEval(3, 20, -1);
        runEval(4, 0, -1);
        runEval(0, 0, WIN0 + 100);
        runEval(0, 0, -1);
        repeat (3) runEval(3, $urandom_range(0, 3), -1);

        repeat (5) @(negedge iClk);
        chk("scoreboard drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/ubfly_collect.md
Name: ubfly_collect

Overview:
- Downstream capture stage for the unary butterfly.
- Sequences one butterfly evaluation: issues the weight-load pulse, discards the pipeline-fill cycles, then counts ones on the four output bitstreams (oReal0, oImg0, oReal1, oImg1) over one full stream period of 2^BITWIDTH cycles.
- Presents the four counts as binary words with a valid/ready handshake to the next FFT stage or a result buffer.

Parameters:
- BITWIDTH, 8, log2 of the stream length L = 2^BITWIDTH. Matches the butterfly weight width.
- SKIP, 2, number of cycles discarded after the load pulse to cover butterfly adder/subtractor pipeline fill. Legal range 0..15.

Ports:
- iClk  in  1  clock
- iRstN  in  1  asynchronous active-low reset
- iStart  in  1  request one evaluation; sampled only in IDLE
- iReal0  in  1  butterfly oReal0 bitstream
- iImg0  in  1  butterfly oImg0 bitstream
- iReal1  in  1  butterfly oReal1 bitstream
- iImg1  in  1  butterfly oImg1 bitstream
- oLoadW  out  1  one-cycle weight-load pulse to the butterfly loadW input
- oBusy  out  1  high in every state except IDLE
- oValid  out  1  result valid; held until accepted
- iReady  in  1  downstream accepts the result when oValid & iReady
- oCntReal0  out  BITWIDTH+1  ones count for the oReal0 stream, range 0..L
- oCntImg0  out  BITWIDTH+1  ones count for the oImg0 stream
- oCntReal1  out  BITWIDTH+1  ones count for the oReal1 stream
- oCntImg1  out  BITWIDTH+1  ones count for the oImg1 stream

Behaviour:
- Reset (async, iRstN=0): state=IDLE; all outputs 0; all counters 0. Applies mid-operation with no partial result kept.
- FSM states: IDLE, LOAD, FILL, ACC, DONE.
- IDLE:
  - iStart=1 -> LOAD next cycle.
  - iStart=0 -> stay in IDLE.
- LOAD (exactly 1 cycle):
  - oLoadW=1.
  - All four accumulators and the cycle counter cleared.
  - Next state is FILL if SKIP>0, else ACC.
- FILL (exactly SKIP cycles):
  - Input streams ignored.
  - Skip counter 4 bits; transition to ACC when it reaches SKIP-1.
- ACC (exactly L cycles):
  - Each cycle, each accumulator increments by its input bit.
  - Cycle counter is BITWIDTH bits. On the cycle where it equals L-1, the final bit is accumulated and the state moves to DONE.
- DONE:
  - oValid=1.
  - oCnt* are registered and stable while oValid=1.
  - oValid & iReady -> IDLE next cycle, and oValid drops.
  - iReady=0 -> hold indefinitely.
- iStart outside IDLE is ignored, including the handshake cycle. A new evaluation requires iStart in IDLE.
- Latency from the iStart sample to oValid rising = 1 + 1 + SKIP + L cycles, which is 260 at the defaults.
- oCnt* hold their last values after acceptance until the next LOAD clears them.
- Accumulator width is BITWIDTH+1 and cannot overflow: maximum count is L (all ones) = 256 for BITWIDTH=8.
- Bipolar interpretation (documented for consumers, not computed here): value = (2*count - L)/L.
- oLoadW is registered: it is high exactly for the LOAD cycle.

Decomposition:
- Shared package: FSM state encoding localparams (IDLE, LOAD, FILL, ACC, DONE, 3-bit); derived constant L = 1<<BITWIDTH; count width BITWIDTH+1.
- One sub-module, ubfly_stream_cnt: single-channel ones counter with synchronous clear and enable, async reset. Instantiated four times. The FSM and the cycle/skip counters live in the top.

Test Plan:
- All four streams tied to 1, pulse iStart, iReady=1 -> oLoadW high on cycle 1; oValid rises 260 cycles after the iStart sample; all counts = 256; oValid drops on the next cycle.
- Streams: iReal0=0, iImg0 toggling 0/1, iReal1 and iImg1 from an LFSR with known ones count K -> counts 0, 128, K, K, with bench-computed references.
- Streams driven to 1 only during the LOAD and FILL cycles, 0 during ACC -> all counts = 0, which proves the fill cycles are discarded.
- In DONE, hold iReady=0 for 20 cycles while the input streams and iStart toggle -> oValid stays 1, counts are unchanged, no new LOAD occurs; raise iReady -> IDLE.
- Assert iStart repeatedly during ACC -> no restart; exactly one result; total latency unchanged.
- Pull iRstN low at ACC cycle 100, release, then run a normal all-ones evaluation -> immediately after reset all outputs = 0 and oBusy = 0; the following result = 256 with no carry-over.
